// File: rtl/leaf_pkg.sv
// Shared page-level constants for leaf_interface and its stream FIFOs.
package leaf_pkg;

  localparam int unsigned PAYLOAD_BITS_DEF   = 32;
  localparam int unsigned FIFO_ADDR_BITS_DEF = 7;

  function automatic int unsigned fifo_depth(input int unsigned addr_bits);
    return 32'd1 << addr_bits;
  endfunction

endpackage

// File: rtl/leaf_stream_fifo_ram.sv
// Simple dual-port RAM: synchronous write, asynchronous read (LUTRAM-style).
module leaf_stream_fifo_ram
  import leaf_pkg::*;
#(
  parameter int unsigned PAYLOAD_BITS = PAYLOAD_BITS_DEF,
  parameter int unsigned ADDR_BITS    = FIFO_ADDR_BITS_DEF
) (
  input  logic                    clk,
  input  logic                    we_i,
  input  logic [ADDR_BITS-1:0]    waddr_i,
  input  logic [PAYLOAD_BITS-1:0] wdata_i,
  input  logic [ADDR_BITS-1:0]    raddr_i,
  output logic [PAYLOAD_BITS-1:0] rdata_o
);

  localparam int unsigned Depth = fifo_depth(ADDR_BITS);

  logic [PAYLOAD_BITS-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/leaf_stream_fifo.sv
// First-word-fall-through elastic buffer between leaf_interface and a kernel input stream.
module leaf_stream_fifo
  import leaf_pkg::*;
#(
  parameter int unsigned PAYLOAD_BITS = PAYLOAD_BITS_DEF,
  parameter int unsigned ADDR_BITS    = FIFO_ADDR_BITS_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PAYLOAD_BITS-1:0] din,
  input  logic                    vld_in,
  output logic                    ack_out,
  output logic [PAYLOAD_BITS-1:0] dout,
  output logic                    vld_out,
  input  logic                    ack_in,
  output logic [ADDR_BITS:0]      level,
  output logic [ADDR_BITS:0]      max_level
);

  localparam logic [ADDR_BITS:0] DepthLvl = (ADDR_BITS+1)'(fifo_depth(ADDR_BITS));

  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]   level_q, level_d;
  logic [ADDR_BITS:0]   max_level_q, max_level_d;
  logic                 full, empty, push, pop;

  assign full  = (level_q == DepthLvl);
  assign empty = (level_q == '0);

  // Reset blocks both handshakes so nothing is accepted or consumed in that cycle.
  assign push = vld_in && !full && !reset;
  assign pop  = !empty && ack_in && !reset;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    max_level_d = max_level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    level_d = level_q + {{ADDR_BITS{1'b0}}, push} - {{ADDR_BITS{1'b0}}, pop};
    if (level_d > max_level_q) begin
      max_level_d = level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      max_level_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      max_level_q <= max_level_d;
    end
  end

  leaf_stream_fifo_ram #(
    .PAYLOAD_BITS (PAYLOAD_BITS),
    .ADDR_BITS    (ADDR_BITS)
  ) u_ram (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (din),
    .raddr_i (rd_ptr_q),
    .rdata_o (dout)
  );

  assign ack_out   = push;
  assign vld_out   = !empty;
  assign level     = level_q;
  assign max_level = max_level_q;

endmodule
